// File: rtl/rv32i_mc_core_if.sv
// Shared instruction/data memory port of the multi-cycle core.
// Registered memory: read data returns the cycle after the request.
interface rv32i_mc_core_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/rv32i_mc_core.sv
// Minimal multi-cycle RV32I core: FETCH -> DECODE -> EXEC (-> LOAD) over one memory port.
// Halts on ECALL, EBREAK or any unsupported encoding.
module rv32i_mc_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  rv32i_mc_core_if.master bus,
  output logic            halt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LOAD, S_HALT
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q, ir_q, rs1_q, rs2_q;
  logic [XLEN-1:0] rf [32];
  logic            req_q, we_q, halt_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s, sra;
    logic [4:0] sh;
    a_s = a;
    b_s = b;
    sh  = b[4:0];
    sra = a_s >>> sh;
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  begin
        if (alt) alu = sra;
        else     alu = a >> sh;
      end
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s;
    a_s = a;
    b_s = b;
    case (f3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = (a_s < b_s);
      3'b101:  br_taken = (a_s >= b_s);
      3'b110:  br_taken = (a < b);
      default: br_taken = (a >= b);
    endcase
  endfunction

  // Decode-cycle view of the fetched word: memory requests must be registered one edge ahead
  logic [4:0]      dec_rs1, dec_rs2;
  logic            dec_ld, dec_st;
  logic [XLEN-1:0] dec_imm, dec_addr;

  assign dec_rs1  = bus.mem_data_i[19:15];
  assign dec_rs2  = bus.mem_data_i[24:20];
  assign dec_ld   = (bus.mem_data_i[6:0] == OP_LOAD)  && (bus.mem_data_i[14:12] == 3'b010);
  assign dec_st   = (bus.mem_data_i[6:0] == OP_STORE) && (bus.mem_data_i[14:12] == 3'b010);
  assign dec_imm  = dec_st ? {{20{bus.mem_data_i[31]}}, bus.mem_data_i[31:25], bus.mem_data_i[11:7]}
                           : {{20{bus.mem_data_i[31]}}, bus.mem_data_i[31:20]};
  assign dec_addr = (rf[dec_rs1] + dec_imm) & ~32'h3;

  // Execute-cycle fields
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j, pc_plus4;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign funct7   = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'b0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  logic            legal, wr_en, is_load;
  logic [XLEN-1:0] result, next_pc;

  always_comb begin
    legal   = 1'b0;
    wr_en   = 1'b0;
    is_load = 1'b0;
    result  = '0;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI: begin
        legal  = 1'b1;
        wr_en  = 1'b1;
        result = imm_u;
      end
      OP_AUIPC: begin
        legal  = 1'b1;
        wr_en  = 1'b1;
        result = pc_q + imm_u;
      end
      OP_JAL: begin
        legal   = 1'b1;
        wr_en   = 1'b1;
        result  = pc_plus4;
        next_pc = pc_q + imm_j;
      end
      OP_JALR: begin
        legal   = (funct3 == 3'b000);
        wr_en   = legal;
        result  = pc_plus4;
        next_pc = (rs1_q + imm_i) & ~32'h1;
      end
      OP_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        if (br_taken(funct3, rs1_q, rs2_q)) next_pc = pc_q + imm_b;
      end
      OP_LOAD: begin
        legal   = (funct3 == 3'b010);
        is_load = legal;
      end
      OP_STORE: legal = (funct3 == 3'b010);
      OP_IMM: begin
        // shift-immediates reuse funct7 to pick SRLI/SRAI; all other encodings are plain imm
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        wr_en  = legal;
        result = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_q, imm_i);
      end
      OP_REG: begin
        legal  = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        wr_en  = legal;
        result = alu(funct3, funct7[5], rs1_q, rs2_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        // FETCH: the first cycle after reset only raises the request
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q & ~32'h3;
          end else begin
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        // DECODE: capture instruction and operands, launch LW/SW for the EXEC cycle
        S_DECODE: begin
          ir_q    <= bus.mem_data_i;
          rs1_q   <= rf[dec_rs1];
          rs2_q   <= rf[dec_rs2];
          state_q <= S_EXEC;
          if (dec_ld || dec_st) begin
            req_q  <= 1'b1;
            we_q   <= dec_st;
            addr_q <= dec_addr;
            if (dec_st) wdata_q <= rf[dec_rs2];
          end
        end
        // EXEC: retire, or hand off to LOAD, or stop
        S_EXEC: begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
          if (!legal) begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end else if (is_load) begin
            state_q <= S_LOAD;
          end else begin
            if (wr_en && (rd != 5'd0)) rf[rd] <= result;
            pc_q    <= next_pc;
            req_q   <= 1'b1;
            addr_q  <= next_pc & ~32'h3;
            state_q <= S_FETCH;
          end
        end
        // LOAD: read data arrives now
        S_LOAD: begin
          if (rd != 5'd0) rf[rd] <= bus.mem_data_i;
          pc_q    <= pc_plus4;
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= pc_plus4 & ~32'h3;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          req_q  <= 1'b0;
          we_q   <= 1'b0;
          halt_q <= 1'b1;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign bus.mem_req_o  = req_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = wdata_q;
  assign halt_o         = halt_q;

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Bench for rv32i_mc_core: small programs in a registered memory model, bus accesses
// checked against a queue of expected {cycle, we, addr, data} events.
module tb_rv32i_mc_core;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic halt;

  rv32i_mc_core_if bus ();

  rv32i_mc_core #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus),
    .halt_o(halt)
  );

  always #5 clk = ~clk;

  // Memory model: program image from the stimulus, stores kept separately until reset
  logic [31:0]   prog  [1024];
  logic [31:0]   dmem  [1024];
  logic [1023:0] dwritten;
  logic [31:0]   rdata;
  logic [9:0]    idx;

  assign idx            = bus.mem_addr_o[11:2];
  assign bus.mem_data_i = rdata;

  always @(posedge clk) begin
    if (!rstn) begin
      dwritten <= '0;
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        dmem[idx]     <= bus.mem_data_o;
        dwritten[idx] <= 1'b1;
      end else begin
        rdata <= dwritten[idx] ? dmem[idx] : prog[idx];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  ev_t  sb[$];
  vec_t vt[21];
  logic [31:0] hw[6];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] opi(input logic [2:0] f3, input logic [11:0] imm);
    return enc_i(imm, 5'd1, f3, 5'd3, 7'b0010011);
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] w);
    prog[addr[11:2]] = w;
  endtask

  task automatic push(input int cyc, input logic we, input logic [31:0] addr,
                      input logic [31:0] data);
    ev_t e;
    e.cyc = cyc; e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, halt} != '0) begin
      bad++;
      $display("FAIL %s: req=%0b we=%0b addr=%h data=%h halt=%0b, required all zero",
               name, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, halt);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_idle("reset_assert");
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rstn = 1'b1;
  endtask

  // Runs ncyc cycles after reset release; halt_cyc = first cycle halt_o must be high (0 = never)
  task automatic run(input string name, input int ncyc, input int halt_cyc);
    ev_t e;
    logic exp_halt;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected_req: cyc=%0d we=%0b addr=%h, required no access",
                   name, c, bus.mem_we_o, bus.mem_addr_o);
        end else begin
          e = sb.pop_front();
          if ((c != e.cyc) || (bus.mem_we_o != e.we) || (bus.mem_addr_o != e.addr) ||
              (e.we && (bus.mem_data_o != e.data))) begin
            bad++;
            $display("FAIL %s access: got cyc=%0d we=%0b addr=%h data=%h, required cyc=%0d we=%0b addr=%h data=%h",
                     name, c, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o,
                     e.cyc, e.we, e.addr, e.data);
          end
        end
      end
      exp_halt = (halt_cyc != 0) && (c >= halt_cyc);
      total++;
      if (halt != exp_halt) begin
        bad++;
        $display("FAIL %s halt: cyc=%0d got %0b required %0b", name, c, halt, exp_halt);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s missing_access: %0d still pending, required 0 (next cyc=%0d addr=%h)",
               name, sb.size(), sb[0].cyc, sb[0].addr);
    end
    sb.delete();
  endtask

  initial begin
    vt[0]  = '{"ADD",   enc_r(7'h00, 3'b000), 32'h7FFF_FFFF, 32'h1,         32'h8000_0000};
    vt[1]  = '{"SUB",   enc_r(7'h20, 3'b000), 32'h0,         32'h1,         32'hFFFF_FFFF};
    vt[2]  = '{"SLL",   enc_r(7'h00, 3'b001), 32'h1,         32'h23,        32'h8};
    vt[3]  = '{"SLT",   enc_r(7'h00, 3'b010), 32'hFFFF_FFFF, 32'h1,         32'h1};
    vt[4]  = '{"SLTU",  enc_r(7'h00, 3'b011), 32'hFFFF_FFFF, 32'h1,         32'h0};
    vt[5]  = '{"XOR",   enc_r(7'h00, 3'b100), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vt[6]  = '{"SRL",   enc_r(7'h00, 3'b101), 32'h8000_0000, 32'h4,         32'h0800_0000};
    vt[7]  = '{"SRA",   enc_r(7'h20, 3'b101), 32'h8000_0000, 32'h4,         32'hF800_0000};
    vt[8]  = '{"OR",    enc_r(7'h00, 3'b110), 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0};
    vt[9]  = '{"AND",   enc_r(7'h00, 3'b111), 32'h0000_FF0F, 32'h0000_0FFF, 32'h0000_0F0F};
    vt[10] = '{"ADDI",  opi(3'b000, 12'hFFF), 32'h0,         32'h0,         32'hFFFF_FFFF};
    vt[11] = '{"SLTI",  opi(3'b010, 12'hFFF), 32'hFFFF_FFFE, 32'h0,         32'h1};
    vt[12] = '{"SLTIU", opi(3'b011, 12'hFFF), 32'h5,         32'h0,         32'h1};
    vt[13] = '{"XORI",  opi(3'b100, 12'h7FF), 32'hFFFF_FFFF, 32'h0,         32'hFFFF_F800};
    vt[14] = '{"ORI",   opi(3'b110, 12'hFF0), 32'h5,         32'h0,         32'hFFFF_FFF5};
    vt[15] = '{"ANDI",  opi(3'b111, 12'h0F0), 32'h1234,      32'h0,         32'h30};
    vt[16] = '{"SLLI",  opi(3'b001, 12'h01F), 32'h1,         32'h0,         32'h8000_0000};
    vt[17] = '{"SRLI",  opi(3'b101, 12'h01F), 32'h8000_0000, 32'h0,         32'h1};
    vt[18] = '{"SRAI",  opi(3'b101, 12'h41F), 32'h8000_0000, 32'h0,         32'hFFFF_FFFF};
    vt[19] = '{"LUI",   {20'hABCDE, 5'd3, 7'b0110111}, 32'h0, 32'h0,        32'hABCD_E000};
    vt[20] = '{"AUIPC", {20'h00001, 5'd3, 7'b0010111}, 32'h0, 32'h0,        32'h0000_1008};

    hw[0] = 32'h0000_0073;                         // ECALL
    hw[1] = 32'h0000_0000;                         // all-zero word
    hw[2] = 32'h0010_0073;                         // EBREAK
    hw[3] = enc_s(12'h100, 5'd2, 5'd0, 3'b000);    // SB: unsupported store width
    hw[4] = enc_r(7'h01, 3'b000);                  // MUL: unsupported funct7
    hw[5] = 32'h0000_000B;                         // custom opcode

    // Reset, ALU + store, then load round trip
    clear_prog();
    set_word(32'h00, 32'h0050_0093);
    set_word(32'h04, 32'h0010_8133);
    set_word(32'h08, 32'h1020_2023);
    set_word(32'h0C, 32'h1000_2183);
    set_word(32'h10, enc_s(12'h104, 5'd3, 5'd0, 3'b010));
    set_word(32'h14, 32'h0000_0073);
    do_reset();
    push(1, 1'b0, 32'h00, 32'h0);  push(4, 1'b0, 32'h04, 32'h0);
    push(7, 1'b0, 32'h08, 32'h0);  push(9, 1'b1, 32'h100, 32'hA);
    push(10, 1'b0, 32'h0C, 32'h0); push(12, 1'b0, 32'h100, 32'h0);
    push(14, 1'b0, 32'h10, 32'h0); push(16, 1'b1, 32'h104, 32'hA);
    push(17, 1'b0, 32'h14, 32'h0);
    run("alu_store_load", 24, 20);

    // Jump and link
    clear_prog();
    set_word(32'h00, 32'h0080_00EF);
    set_word(32'h04, 32'h0000_0073);
    set_word(32'h08, enc_s(12'h200, 5'd1, 5'd0, 3'b010));
    set_word(32'h0C, 32'h0000_0073);
    do_reset();
    push(1, 1'b0, 32'h00, 32'h0); push(4, 1'b0, 32'h08, 32'h0);
    push(6, 1'b1, 32'h200, 32'h4); push(7, 1'b0, 32'h0C, 32'h0);
    run("jal", 14, 10);

    // Branches with x1=-1, x2=1, then JALR to an odd target
    clear_prog();
    set_word(32'h00, opi(3'b000, 12'hFFF) & 32'hFFFF_F07F | 32'h0000_0080 & 32'h0000_0F80);
    set_word(32'h00, enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011));
    set_word(32'h04, enc_i(12'h001, 5'd0, 3'b000, 5'd2, 7'b0010011));
    set_word(32'h08, enc_b(13'd8, 5'd2, 5'd2, 3'b000));
    set_word(32'h0C, 32'h0000_0073);
    set_word(32'h10, enc_b(13'd8, 5'd2, 5'd1, 3'b000));
    set_word(32'h14, enc_b(13'd8, 5'd2, 5'd1, 3'b100));
    set_word(32'h18, 32'h0000_0073);
    set_word(32'h1C, enc_b(13'd8, 5'd2, 5'd1, 3'b110));
    set_word(32'h20, enc_b(13'd8, 5'd2, 5'd1, 3'b001));
    set_word(32'h24, 32'h0000_0073);
    set_word(32'h28, enc_b(13'd8, 5'd2, 5'd1, 3'b101));
    set_word(32'h2C, enc_b(13'd8, 5'd2, 5'd1, 3'b111));
    set_word(32'h30, 32'h0000_0073);
    set_word(32'h34, enc_i(12'h041, 5'd0, 3'b000, 5'd5, 7'b1100111));
    set_word(32'h38, 32'h0000_0073);
    set_word(32'h40, enc_s(12'h204, 5'd5, 5'd0, 3'b010));
    set_word(32'h44, 32'h0010_0073);
    do_reset();
    push(1,  1'b0, 32'h00, 32'h0); push(4,  1'b0, 32'h04, 32'h0);
    push(7,  1'b0, 32'h08, 32'h0); push(10, 1'b0, 32'h10, 32'h0);
    push(13, 1'b0, 32'h14, 32'h0); push(16, 1'b0, 32'h1C, 32'h0);
    push(19, 1'b0, 32'h20, 32'h0); push(22, 1'b0, 32'h28, 32'h0);
    push(25, 1'b0, 32'h2C, 32'h0); push(28, 1'b0, 32'h34, 32'h0);
    push(31, 1'b0, 32'h40, 32'h0); push(33, 1'b1, 32'h204, 32'h38);
    push(34, 1'b0, 32'h44, 32'h0);
    run("branch_jalr", 40, 37);

    // Reset during EXEC aborts the write and clears the register file
    clear_prog();
    set_word(32'h00, 32'h0050_0093);
    set_word(32'h04, enc_i(12'h007, 5'd0, 3'b000, 5'd2, 7'b0010011));
    do_reset();
    push(1, 1'b0, 32'h00, 32'h0); push(4, 1'b0, 32'h04, 32'h0);
    run("abort_part1", 6, 0);
    clear_prog();
    set_word(32'h00, enc_s(12'h100, 5'd1, 5'd0, 3'b010));
    set_word(32'h04, enc_s(12'h104, 5'd2, 5'd0, 3'b010));
    set_word(32'h08, 32'h0000_0073);
    do_reset();
    push(1, 1'b0, 32'h00, 32'h0);  push(3, 1'b1, 32'h100, 32'h0);
    push(4, 1'b0, 32'h04, 32'h0);  push(6, 1'b1, 32'h104, 32'h0);
    push(7, 1'b0, 32'h08, 32'h0);
    run("abort_part2", 12, 10);

    // Halting encodings: one fetch, then nothing until reset
    for (int h = 0; h < 6; h++) begin
      clear_prog();
      set_word(32'h00, hw[h]);
      set_word(32'h04, 32'h0050_0093);
      do_reset();
      push(1, 1'b0, 32'h00, 32'h0);
      run($sformatf("halt_%0d", h), 10, 4);
    end

    // ALU vectors: LW x1, LW x2, op x3, SW x3, ECALL
    for (int v = 0; v < 21; v++) begin
      clear_prog();
      set_word(32'h00, enc_i(12'h300, 5'd0, 3'b010, 5'd1, 7'b0000011));
      set_word(32'h04, enc_i(12'h304, 5'd0, 3'b010, 5'd2, 7'b0000011));
      set_word(32'h08, vt[v].instr);
      set_word(32'h0C, enc_s(12'h308, 5'd3, 5'd0, 3'b010));
      set_word(32'h10, 32'h0000_0073);
      set_word(32'h300, vt[v].a);
      set_word(32'h304, vt[v].b);
      do_reset();
      push(1,  1'b0, 32'h00,  32'h0); push(3,  1'b0, 32'h300, 32'h0);
      push(5,  1'b0, 32'h04,  32'h0); push(7,  1'b0, 32'h304, 32'h0);
      push(9,  1'b0, 32'h08,  32'h0); push(12, 1'b0, 32'h0C,  32'h0);
      push(14, 1'b1, 32'h308, vt[v].exp);
      push(15, 1'b0, 32'h10,  32'h0);
      run(vt[v].name, 20, 18);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_core.md
Name: rv32i_mc_core

Overview:
Minimal multi-cycle RV32I integer core. It is the top-level compute block of the SoC, driving a single shared instruction/data memory port. It executes the base integer ISA, without CSR, FENCE or sub-word loads and stores, from a fixed reset vector. It halts on ECALL, EBREAK or any unsupported encoding.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
XLEN, 32, data/address width; only 32 is supported

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rstn_i  in  1  asynchronous active-low reset
mem_req_o  out  1  memory access request, asserted for exactly one cycle per access
mem_we_o  out  1  1 = write, 0 = read; qualified by mem_req_o
mem_addr_o  out  32  byte address; bits [1:0] always 0
mem_data_o  out  32  store data; valid when mem_req_o & mem_we_o
mem_data_i  in  32  read data; valid the cycle after a read request (registered memory)
halt_o  out  1  core has stopped; stays high until reset

Behaviour:
- Clock and reset: one clock, clk_i; reset rstn_i is asynchronous, active-low.
- Reset values while rstn_i=0, and immediately on assertion:
  - pc=RESET_PC, state=FETCH.
  - x0..x31 = 0.
  - mem_req_o, mem_we_o, halt_o = 0; mem_addr_o, mem_data_o = 0.
  - Asserting reset mid-instruction aborts it; no partial register write survives.
- State machine: FETCH -> DECODE -> EXEC -> (LOAD for LW) -> FETCH. HALT is terminal.
- FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o=pc.
- DECODE: latch mem_data_i into the instruction register; read rs1 and rs2.
- EXEC:
  - ALU ops, branches and jumps write rd and update pc this cycle.
  - SW: mem_req_o=1, mem_we_o=1, mem_addr_o = rs1 + sext(imm) with [1:0] forced to 0, mem_data_o = rs2.
  - LW: read request issued at the same address.
- LOAD: rd <= mem_data_i; pc <= pc+4.
- Latency: LW 4 cycles; every other instruction 3 cycles.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Arithmetic: wrap modulo 2^32, no overflow flag. Shifts use shamt[4:0]. SLT/BLT are signed; SLTU/BLTU are unsigned. Immediates are sign-extended per RV32I formats.
- Branch: taken -> pc += sext(B-imm); not taken -> pc += 4.
- Jumps: JAL/JALR write pc+4 to rd, computed from the jumping instruction's own pc.
- Writes to x0 are discarded; x0 always reads 0.
- Misaligned targets: pc low bits are forced to 0 on fetch; no exception is raised.
- Halt: ECALL, EBREAK, all-zero word, or any unlisted opcode/funct3/funct7.
  - Enter HALT from EXEC with no register or memory side effect.
  - halt_o=1; mem_req_o held 0 until reset.
- No other traps, interrupts or stalls; memory is assumed always ready.

Test Plan:
1. Reset: hold rstn_i=0 for 3 cycles, then release.
   -> First mem_req_o=1, mem_we_o=0, mem_addr_o=0x0000_0000 in the first cycle after release; halt_o=0.
2. ALU + store: memory[0]=0x00500093 (ADDI x1,x0,5), [4]=0x00108133 (ADD x2,x1,x1), [8]=0x10202023 (SW x2,0x100(x0)).
   -> Write at cycle 9: mem_we_o=1, mem_addr_o=0x100, mem_data_o=0x0000_000A.
3. Load round trip: continue test 2 with [12]=0x10002183 (LW x3,0x100(x0)) and [16]=SW x3,0x104(x0).
   -> Read of 0x100, then write to 0x104 with data 0x0A; LW takes 4 cycles.
4. Jump/link: [0]=0x008000EF (JAL x1,+8), [8]=SW x1,0x200(x0).
   -> Next fetch address is 0x8, not 0x4; store writes 0x0000_0004 to 0x200.
5. Branch: BEQ taken and not taken, BLT vs BLTU with x1=0xFFFF_FFFF, x2=1.
   -> BLT taken; BLTU not taken; verify fetch addresses.
6. Halt: [0]=0x00000073 (ECALL), then a separate run with 0x00000000.
   -> halt_o=1 after EXEC; no further mem_req_o. Asserting rstn_i=0 clears halt_o and restarts at RESET_PC.
